// File: rtl/ppm_serial_correlator.sv
// Serial PPM correlator. Chip counts arrive one slot per cycle, slot 0 first.
// Per-slot counts are summed over NUM_FRAMES frames, the slot array is then
// scanned for the peak (lowest index wins ties), and the decision is held on a
// valid/ready output until the deframer takes it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ACCUM | accepting chips, building per-slot sums
// ST_SCAN  | walking slots 0..SLOTS-1, tracking the running peak
// ST_HOLD  | decision presented, waiting for out_ready
module ppm_serial_correlator #(
  parameter int  CHIP_BITS  = 3,
  parameter int  LOG2_SLOTS = 4,
  parameter int  NUM_FRAMES = 1,
  localparam int ACC_W      = CHIP_BITS + $clog2(NUM_FRAMES)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  sync_clear,
  input  logic [CHIP_BITS-1:0]  chip_in,
  input  logic                  chip_valid,
  output logic                  chip_ready,
  input  logic [ACC_W-1:0]      corr_threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LOG2_SLOTS-1:0] symbol,
  output logic [ACC_W-1:0]      peak_value,
  output logic                  threshold_unmet
);

  localparam int SLOTS   = 2 ** LOG2_SLOTS;
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [LOG2_SLOTS-1:0] LAST_SLOT  = LOG2_SLOTS'(SLOTS - 1);
  localparam logic [FRAME_W-1:0]    LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LOG2_SLOTS-1:0] slot_q, slot_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [ACC_W-1:0]      best_q, best_d;
  logic [LOG2_SLOTS-1:0] best_idx_q, best_idx_d;
  logic [LOG2_SLOTS-1:0] symbol_q, symbol_d;
  logic [ACC_W-1:0]      peak_q, peak_d;
  logic                  unmet_q, unmet_d;

  logic [ACC_W-1:0]      acc_q [SLOTS];
  logic                  acc_we;
  logic [ACC_W-1:0]      acc_wdata;
  logic [ACC_W-1:0]      cand;
  logic [ACC_W-1:0]      scan_peak;
  logic [LOG2_SLOTS-1:0] scan_idx;

  // Next-state, counter and decision logic; slot_q doubles as the scan index.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    frame_d    = frame_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    symbol_d   = symbol_q;
    peak_d     = peak_q;
    unmet_d    = unmet_q;
    acc_we     = 1'b0;
    acc_wdata  = '0;
    cand       = acc_q[slot_q];
    scan_peak  = best_q;
    scan_idx   = best_idx_q;
    chip_ready = (state_q == ST_ACCUM);
    out_valid  = (state_q == ST_HOLD);

    // Slot 0 seeds the running peak so stale best_q never leaks across decisions.
    if ((slot_q == '0) || (cand > best_q)) begin
      scan_peak = cand;
      scan_idx  = slot_q;
    end

    if (sync_clear) begin
      state_d = ST_ACCUM;
      slot_d  = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (chip_valid) begin
            acc_we    = 1'b1;
            acc_wdata = (frame_q == '0) ? ACC_W'(chip_in) : cand + ACC_W'(chip_in);
            if (slot_q == LAST_SLOT) begin
              slot_d = '0;
              if (frame_q == LAST_FRAME) begin
                frame_d = '0;
                state_d = ST_SCAN;
              end else begin
                frame_d = frame_q + FRAME_W'(1);
              end
            end else begin
              slot_d = slot_q + LOG2_SLOTS'(1);
            end
          end
        end
        ST_SCAN: begin
          best_d     = scan_peak;
          best_idx_d = scan_idx;
          if (slot_q == LAST_SLOT) begin
            slot_d   = '0;
            symbol_d = scan_idx;
            peak_d   = scan_peak;
            unmet_d  = (scan_peak < corr_threshold);
            state_d  = ST_HOLD;
          end else begin
            slot_d = slot_q + LOG2_SLOTS'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_ACCUM;
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  // Control and decision registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_ACCUM;
      slot_q     <= '0;
      frame_q    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      symbol_q   <= '0;
      peak_q     <= '0;
      unmet_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      symbol_q   <= symbol_d;
      peak_q     <= peak_d;
      unmet_q    <= unmet_d;
    end
  end

  // Slot sums; frame 0 overwrites, so no reset or clear pass is needed.
  always_ff @(posedge clk) begin
    if (acc_we) acc_q[slot_q] <= acc_wdata;
  end

  assign symbol          = symbol_q;
  assign peak_value      = peak_q;
  assign threshold_unmet = unmet_q;

endmodule

// File: tb/tb_ppm_serial_correlator.sv
// Bench for ppm_serial_correlator: one NUM_FRAMES=1 and one NUM_FRAMES=4
// instance, directed cases followed by randomized frames against a sum/argmax
// reference model.
module tb_ppm_serial_correlator;

  logic clk = 1'b0;
  logic rstb;

  logic       sc1, cv1, cr1, ov1, or1, un1;
  logic [2:0] ci1, th1, pk1;
  logic [3:0] sym1;

  logic       sc4, cv4, cr4, ov4, or4, un4;
  logic [2:0] ci4;
  logic [4:0] th4, pk4;
  logic [3:0] sym4;

  int n_cmp  = 0;
  int n_fail = 0;
  int frame_buf [4][16];

  always #5 clk = ~clk;

  ppm_serial_correlator #(.CHIP_BITS(3), .LOG2_SLOTS(4), .NUM_FRAMES(1)) u_dut1 (
    .clk(clk), .rstb(rstb), .sync_clear(sc1), .chip_in(ci1), .chip_valid(cv1),
    .chip_ready(cr1), .corr_threshold(th1), .out_valid(ov1), .out_ready(or1),
    .symbol(sym1), .peak_value(pk1), .threshold_unmet(un1));

  ppm_serial_correlator #(.CHIP_BITS(3), .LOG2_SLOTS(4), .NUM_FRAMES(4)) u_dut4 (
    .clk(clk), .rstb(rstb), .sync_clear(sc4), .chip_in(ci4), .chip_valid(cv4),
    .chip_ready(cr4), .corr_threshold(th4), .out_valid(ov4), .out_ready(or4),
    .symbol(sym4), .peak_value(pk4), .threshold_unmet(un4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 1) ? cr1 : cr4;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 1) ? ov1 : ov4;
  endfunction
  function automatic logic get_un(input int w);
    return (w == 1) ? un1 : un4;
  endfunction
  function automatic logic [31:0] get_sym(input int w);
    return (w == 1) ? {28'd0, sym1} : {28'd0, sym4};
  endfunction
  function automatic logic [31:0] get_pk(input int w);
    return (w == 1) ? {29'd0, pk1} : {27'd0, pk4};
  endfunction

  task automatic clear_buf();
    for (int f = 0; f < 4; f++)
      for (int s = 0; s < 16; s++) frame_buf[f][s] = 0;
  endtask

  // Offer one chip and wait (bounded) until the DUT takes it; returns at the
  // falling edge just after the accepting rising edge.
  task automatic push(input int w, input int v);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (w == 1) begin cv1 = 1'b1; ci1 = 3'(v); end
    else        begin cv4 = 1'b1; ci4 = 3'(v); end
    while (!acc && n < 100) begin
      acc = get_rdy(w);
      @(negedge clk);
      n++;
    end
    if (w == 1) cv1 = 1'b0; else cv4 = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic idle(input int w, input int cycles);
    repeat (cycles) begin
      if (w == 1) ci1 = 3'($urandom); else ci4 = 3'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic push_frames(input int w, input int nf, input bit gaps);
    for (int f = 0; f < nf; f++)
      for (int s = 0; s < 16; s++) begin
        if (gaps) idle(w, $urandom_range(0, 2));
        push(w, frame_buf[f][s]);
      end
  endtask

  // Reference: per-slot totals, then the largest total, then the first slot
  // reaching it.
  task automatic model(input int nf, input int thr, output int esym, output int epk,
                       output int eun);
    int sums [16];
    epk = 0;
    for (int s = 0; s < 16; s++) begin
      sums[s] = 0;
      for (int f = 0; f < nf; f++) sums[s] += frame_buf[f][s];
      if (sums[s] > epk) epk = sums[s];
    end
    esym = -1;
    for (int s = 0; s < 16; s++)
      if (esym < 0 && sums[s] == epk) esym = s;
    eun = (epk < thr) ? 1 : 0;
  endtask

  task automatic do_decision(input int w, input int nf, input int thr, input bit gaps,
                             input int hold, input string tag);
    int esym, epk, eun, n;
    if (w == 1) th1 = 3'(thr); else th4 = 5'(thr);
    push_frames(w, nf, gaps);
    model(nf, thr, esym, epk, eun);
    n = 0;
    while (!get_ov(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_sym"}, get_sym(w), esym);
    chk({tag, "_peak"}, get_pk(w), epk);
    chk({tag, "_unmet"}, get_un(w), eun);
    chk({tag, "_ready_low"}, get_rdy(w), 0);
    if (hold > 0) begin
      repeat (hold) idle(w, 1);
      chk({tag, "_hold_valid"}, get_ov(w), 1);
      chk({tag, "_hold_sym"}, get_sym(w), esym);
      chk({tag, "_hold_peak"}, get_pk(w), epk);
      chk({tag, "_hold_ready"}, get_rdy(w), 0);
    end
    if (w == 1) or1 = 1'b1; else or4 = 1'b1;
    @(negedge clk);
    if (w == 1) or1 = 1'b0; else or4 = 1'b0;
    chk({tag, "_post_valid"}, get_ov(w), 0);
    chk({tag, "_post_ready"}, get_rdy(w), 1);
    chk({tag, "_post_sym"}, get_sym(w), esym);
  endtask

  initial begin
    int thr, n;
    rstb = 1'b0;
    sc1 = 0; cv1 = 0; or1 = 0; ci1 = 0; th1 = 0;
    sc4 = 0; cv4 = 0; or4 = 0; ci4 = 0; th4 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready1", cr1, 1);
    chk("rst_valid1", ov1, 0);
    chk("rst_sym1", sym1, 0);
    chk("rst_peak1", pk1, 0);
    chk("rst_unmet1", un1, 0);
    chk("rst_ready4", cr4, 1);
    chk("rst_valid4", ov4, 0);
    rstb = 1'b1;
    @(negedge clk);

    // Reference frame, confident and then below threshold.
    clear_buf();
    frame_buf[0] = '{2, 3, 4, 5, 2, 1, 0, 0, 1, 2, 3, 6, 0, 0, 0, 0};
    do_decision(1, 1, 2, 1'b0, 0, "t1");
    chk("t1_sym_abs", sym1, 11);
    chk("t1_peak_abs", pk1, 6);
    chk("t1_unmet_abs", un1, 0);
    do_decision(1, 1, 7, 1'b0, 0, "t2");
    chk("t2_unmet_abs", un1, 1);

    // Tie resolves to the lower slot.
    clear_buf();
    frame_buf[0][3] = 7;
    frame_buf[0][9] = 7;
    do_decision(1, 1, 0, 1'b0, 0, "t3");
    chk("t3_sym_abs", sym1, 3);
    chk("t3_peak_abs", pk1, 7);

    // All-zero frame; threshold 0 never flags, threshold 1 does.
    clear_buf();
    do_decision(1, 1, 0, 1'b0, 0, "zero_thr0");
    chk("zero_peak_abs", pk1, 0);
    do_decision(1, 1, 1, 1'b0, 0, "zero_thr1");

    // Four-frame accumulation: slot 5 totals 4, below slot 12's single 7.
    clear_buf();
    for (int f = 0; f < 4; f++) frame_buf[f][5] = 1;
    frame_buf[0][12] = 7;
    do_decision(4, 4, 5, 1'b0, 0, "t4a");
    chk("t4a_sym_abs", sym4, 12);
    chk("t4a_peak_abs", pk4, 7);
    clear_buf();
    for (int f = 0; f < 4; f++) frame_buf[f][5] = 3;
    do_decision(4, 4, 13, 1'b0, 0, "t4b");
    chk("t4b_sym_abs", sym4, 5);
    chk("t4b_peak_abs", pk4, 12);
    chk("t4b_unmet_abs", un4, 1);

    // sync_clear while a decision is pending drops it.
    for (int s = 0; s < 16; s++) frame_buf[0][s] = $urandom_range(0, 7);
    push_frames(4, 4, 1'b0);
    n = 0;
    while (!ov4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_clr_valid_before", ov4, 1);
    sc4 = 1'b1;
    @(negedge clk);
    sc4 = 1'b0;
    chk("hold_clr_valid_after", ov4, 0);
    chk("hold_clr_ready_after", cr4, 1);

    // sync_clear part way into a frame, with a chip offered in that cycle.
    clear_buf();
    for (int s = 0; s < 7; s++) push(1, 7);
    sc1 = 1'b1; cv1 = 1'b1; ci1 = 3'd7;
    @(negedge clk);
    sc1 = 1'b0; cv1 = 1'b0;
    chk("sclr_ready", cr1, 1);
    chk("sclr_valid", ov1, 0);
    frame_buf[0][9] = 5;
    frame_buf[0][2] = 4;
    do_decision(1, 1, 7, 1'b0, 0, "sclr_next");

    // Reset pulse mid-SCAN clears outputs at once; next frame decodes cleanly.
    for (int s = 0; s < 16; s++) frame_buf[0][s] = $urandom_range(1, 7);
    push_frames(1, 1, 1'b0);
    repeat (5) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("arst_valid", ov1, 0);
    chk("arst_sym", sym1, 0);
    chk("arst_peak", pk1, 0);
    chk("arst_unmet", un1, 0);
    chk("arst_ready", cr1, 1);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("arst_no_stale_valid", ov1, 0);
    clear_buf();
    frame_buf[0][14] = 3;
    frame_buf[0][1]  = 2;
    do_decision(1, 1, 3, 1'b0, 0, "arst_next");

    // Randomized frames with input gaps and downstream backpressure.
    for (int i = 0; i < 200; i++) begin
      for (int s = 0; s < 16; s++) frame_buf[0][s] = $urandom_range(0, 7);
      thr = $urandom_range(0, 7);
      do_decision(1, 1, thr, 1'b1, (i % 4 == 0) ? 10 : $urandom_range(0, 3), "rnd1");
    end
    for (int i = 0; i < 20; i++) begin
      for (int f = 0; f < 4; f++)
        for (int s = 0; s < 16; s++) frame_buf[f][s] = $urandom_range(0, 7);
      thr = $urandom_range(0, 31);
      do_decision(4, 4, thr, 1'b1, (i % 2 == 0) ? 10 : 0, "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
